// File: rtl/m6809_pkg.sv
// m6809_pkg -- shared constants for the 6809 stack push/pull/regmove logic.
//   OP_*  : stack opcode values as seen in the instruction register
//   SEL_* : post-byte bit index of each register (write-back select codes)
//   state_e : sequencer state encoding
//   is_pull() : true for the two pull opcodes
package m6809_pkg;

    localparam logic [7:0] OP_PSHS = 8'h34;
    localparam logic [7:0] OP_PULS = 8'h35;
    localparam logic [7:0] OP_PSHU = 8'h36;
    localparam logic [7:0] OP_PULU = 8'h37;

    localparam logic [2:0] SEL_CC = 3'd0;
    localparam logic [2:0] SEL_A  = 3'd1;
    localparam logic [2:0] SEL_B  = 3'd2;
    localparam logic [2:0] SEL_DP = 3'd3;
    localparam logic [2:0] SEL_X  = 3'd4;
    localparam logic [2:0] SEL_Y  = 3'd5;
    localparam logic [2:0] SEL_SP = 3'd6;
    localparam logic [2:0] SEL_PC = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAD    = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

    function automatic logic is_pull(input logic [7:0] op);
        return (op == OP_PULS) || (op == OP_PULU);
    endfunction

endpackage

// File: rtl/m6809_core_regpull_if.sv
// m6809_core_regpull_if -- request, memory-read and write-back signals of the
// register pull sequencer.
//   request   : ir_in, din (post-byte), start, sp_in
//   memory    : mem_rd, mem_addr, mem_din (data one cycle after mem_rd)
//   writeback : reg_we, reg_sel, reg_data, sp_we, sp_out, stk_sel
//   status    : busy, done
// stk_sel tells which stack pointer sp_out belongs to (0 = S, 1 = U); it is
// only non-zero alongside sp_we.
// modport slave  : the sequencer
// modport master : the CPU core / environment driving it
interface m6809_core_regpull_if;
    logic [7:0]  ir_in;
    logic [7:0]  din;
    logic        start;
    logic [15:0] sp_in;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        reg_we;
    logic [2:0]  reg_sel;
    logic [15:0] reg_data;
    logic        sp_we;
    logic [15:0] sp_out;
    logic        stk_sel;
    logic        busy;
    logic        done;

    modport slave (
        input  ir_in, din, start, sp_in, mem_din,
        output mem_rd, mem_addr, reg_we, reg_sel, reg_data,
               sp_we, sp_out, stk_sel, busy, done
    );

    modport master (
        output ir_in, din, start, sp_in, mem_din,
        input  mem_rd, mem_addr, reg_we, reg_sel, reg_data,
               sp_we, sp_out, stk_sel, busy, done
    );
endinterface

// File: rtl/m6809_core_pullorder.sv
// m6809_core_pullorder -- picks the next register to pull.
//   mask : post-byte bits still to be pulled
//   idx  : index of the lowest set bit (0 when mask is empty)
//   is16 : selected register is 16 bits wide (X, Y, U/S, PC)
module m6809_core_pullorder
    import m6809_pkg::*;
(
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       is16
);

    // Scan downwards so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
    end

    assign is16 = (idx >= SEL_X);

endmodule

// File: rtl/m6809_core_regpull.sv
// m6809_core_regpull -- PULS/PULU register pull sequencer.
//   clk     : system clock, rising edge
//   reset_b : asynchronous active-low reset
//   bus     : m6809_core_regpull_if.slave (request, memory read, write-back)
// Each pulled byte takes a READ cycle (address out) and a CAPTURE cycle
// (data sampled at its end). A completed register is written back in the
// following cycle, overlapping the next READ.
// Build option: M6809_REGPULL_DEAD_CYCLE_EN inserts one idle busy cycle
// between the start edge and the first READ (or FINISH for post-byte 0x00).
//
// state      | meaning
// IDLE       | waiting for a pull start
// DEAD       | optional idle cycle before the first read
// READ       | mem_rd high, mem_addr = internal SP
// CAPTURE    | read data sampled at cycle end, SP incremented
// FINISH     | done / sp_we pulse, last write-back
module m6809_core_regpull
    import m6809_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_b,
    m6809_core_regpull_if.slave   bus
);

    state_e      state_q, state_d;
    logic [7:0]  pb_q, pb_d;
    logic [15:0] sp_q, sp_d;
    logic        stk_sel_q, stk_sel_d;
    logic        hi_q, hi_d;
    logic [7:0]  acc_hi_q, acc_hi_d;
    logic        wb_pend_q, wb_pend_d;
    logic [2:0]  wb_sel_q, wb_sel_d;
    logic [15:0] wb_data_q, wb_data_d;

    logic [2:0]  cur_idx;
    logic        cur_is16;
    logic [7:0]  cur_bit;

    m6809_core_pullorder u_order (
        .mask (pb_q),
        .idx  (cur_idx),
        .is16 (cur_is16)
    );

    assign cur_bit = 8'h01 << cur_idx;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            pb_q      <= '0;
            sp_q      <= '0;
            stk_sel_q <= 1'b0;
            hi_q      <= 1'b0;
            acc_hi_q  <= '0;
            wb_pend_q <= 1'b0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pb_q      <= pb_d;
            sp_q      <= sp_d;
            stk_sel_q <= stk_sel_d;
            hi_q      <= hi_d;
            acc_hi_q  <= acc_hi_d;
            wb_pend_q <= wb_pend_d;
            wb_sel_q  <= wb_sel_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pb_d      = pb_q;
        sp_d      = sp_q;
        stk_sel_d = stk_sel_q;
        hi_d      = hi_q;
        acc_hi_d  = acc_hi_q;
        wb_pend_d = 1'b0;
        wb_sel_d  = wb_sel_q;
        wb_data_d = wb_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && is_pull(bus.ir_in)) begin
                    pb_d      = bus.din;
                    stk_sel_d = bus.ir_in[1];
                    sp_d      = bus.sp_in;
                    hi_d      = 1'b0;
`ifdef M6809_REGPULL_DEAD_CYCLE_EN
                    state_d   = ST_DEAD;
`else
                    state_d   = (bus.din == 8'h00) ? ST_FINISH : ST_READ;
`endif
                end
            end
            ST_DEAD: begin
                state_d = (pb_q == 8'h00) ? ST_FINISH : ST_READ;
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                sp_d = sp_q + 16'd1;
                if (cur_is16 && !hi_q) begin
                    // High byte of a 16-bit register: hold it, stay on this bit.
                    acc_hi_d = bus.mem_din;
                    hi_d     = 1'b1;
                    state_d  = ST_READ;
                end else begin
                    wb_pend_d = 1'b1;
                    wb_sel_d  = cur_idx;
                    wb_data_d = cur_is16 ? {acc_hi_q, bus.mem_din} : {8'h00, bus.mem_din};
                    pb_d      = pb_q & ~cur_bit;
                    hi_d      = 1'b0;
                    state_d   = (pb_d == 8'h00) ? ST_FINISH : ST_READ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_rd   = (state_q == ST_READ);
    assign bus.mem_addr = (state_q == ST_READ) ? sp_q : 16'h0000;
    assign bus.reg_we   = wb_pend_q;
    assign bus.reg_sel  = wb_pend_q ? wb_sel_q : 3'd0;
    assign bus.reg_data = wb_pend_q ? wb_data_q : 16'h0000;
    assign bus.done     = (state_q == ST_FINISH);
    assign bus.sp_we    = (state_q == ST_FINISH);
    assign bus.sp_out   = (state_q == ST_FINISH) ? sp_q : 16'h0000;
    assign bus.stk_sel  = (state_q == ST_FINISH) && stk_sel_q;
    assign bus.busy     = (state_q == ST_DEAD) || (state_q == ST_READ) ||
                          (state_q == ST_CAPTURE);

endmodule

// File: doc/m6809_core_regpull.md
M6809_CORE_REGPULL -- requirements
Module: m6809_core_regpull

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 ir_in  input  8  instruction register; 0x35 = PULS, 0x37 = PULU.
REQ-005 din  input  8  post-byte; captured directly off this input on the start edge.
REQ-006 start  input  1  one-cycle pulse, coincident with the post-byte register update.
REQ-007 sp_in  input  16  active stack pointer: S for PULS, U for PULU.
REQ-008 mem_din  input  8  read data; valid in the cycle after mem_rd.
REQ-009 mem_rd  output  1  memory read strobe.
REQ-010 mem_addr  output  16  read address.
REQ-011 reg_we  output  1  register write-back strobe (one cycle).
REQ-012 reg_sel  output  3  post-byte bit index of the register written: 0 CC, 1 A, 2 B, 3 DP, 4 X, 5 Y, 6 other stack pointer (U for PULS, S for PULU), 7 PC.
REQ-013 reg_data  output  16  write-back data; 8-bit registers use bits [7:0], bits [15:8] = 0.
REQ-014 sp_we, sp_out  output  1, 16  final stack-pointer write strobe and value.
REQ-015 busy, done  output  1, 1  busy = operation in progress; done = one-cycle completion pulse.

Function
REQ-016 States: IDLE, READ (mem_rd=1, mem_addr=SP), CAPTURE (mem_rd=0, data sampled at the cycle's end), FINISH.
REQ-017 In IDLE, a start with ir_in equal to 0x35 or 0x37 SHALL latch din into the post-byte, ir_in bit 1 into the stack select, and sp_in into the internal SP; any other opcode is ignored.
REQ-018 Registers are pulled in ascending bit order: CC, A, B, DP, X, Y, U/S, PC; the next bit is the lowest set bit remaining.
REQ-019 Each byte costs two cycles (READ then CAPTURE); the internal SP increments by 1 at every CAPTURE and wraps from 0xFFFF to 0x0000.
REQ-020 16-bit registers are read high byte first (lower address), then low byte.
REQ-021 reg_we pulses for one cycle, in the cycle after the final byte of a register is captured; this overlaps the next READ.
REQ-022 With N bytes to pull, done, sp_we, and the final reg_we (if any) SHALL assert together in cycle 2N+1 after the start edge; busy is high from cycle 1 through cycle 2N.
REQ-023 For post-byte 0x00, done and sp_we SHALL pulse in cycle 1 with sp_out = sp_in, no reads, and busy never asserted.
REQ-024 A start while busy SHALL be ignored; the post-byte and SP are not re-latched.

Reset
REQ-025 While reset_b = 0, all outputs SHALL be 0, the state SHALL be IDLE, and all internal registers SHALL be 0.
REQ-026 Reset mid-operation SHALL abort it immediately, with no further reg_we, sp_we, or done.

Configuration
REQ-027 With M6809_REGPULL_DEAD_CYCLE_EN defined, one dead cycle (no mem_rd, busy = 1) SHALL precede the first READ, and all latencies grow by 1, including the 0x00 case (done in cycle 2).
REQ-028 Without the macro, timing SHALL be exactly as in REQ-022 and REQ-023.

Structure
REQ-029 Package m6809_pkg SHALL hold the opcode constants (PSHS, PULS, PSHU, PULU), the reg_sel codes, and the state encoding, shared with the push/regmove logic.
REQ-030 Sub-module m6809_core_pullorder SHALL provide the combinational lowest-set-bit encoder and the 8-bit versus 16-bit width flag.

Verification
REQ-031 PULS with post-byte 0x06, sp_in 0x1000, memory [0x1000]=0x11 and [0x1001]=0x22 -> reads at 0x1000 (cycle 1) and 0x1001 (cycle 3); reg_we A=0x0011 in cycle 3; B=0x0022, sp_out 0x1002, and done in cycle 5.
REQ-032 PULU with post-byte 0xC0 at 0x2000, memory bytes 0xAA, 0xBB, 0xCC, 0xDD -> reg_sel 6 (S) = 0xAABB, then PC = 0xCCDD; sp_out 0x2004; done in cycle 9.
REQ-033 Post-byte 0x00 -> done and sp_we in cycle 1, sp_out = sp_in, mem_rd never asserted.
REQ-034 PULS with post-byte 0x80, sp_in 0xFFFF -> reads at 0xFFFF then 0x0000; sp_out 0x0001.
REQ-035 Reset asserted in cycle 3 of a post-byte 0xFF pull, second start while busy, and ir_in = 0x34 with start -> outputs zero with no done after reset; second start ignored; ir_in 0x34 causes no activity.
REQ-036 Repeat REQ-031 with M6809_REGPULL_DEAD_CYCLE_EN defined -> first read in cycle 2, done in cycle 6.
